// File: rtl/seg_bcd_scan.sv
// Binary-to-BCD conversion (sequential double-dabble) driving a 6-digit multiplexed
// common-anode seven-segment display. Optional macro: SEG_LEADING_ZERO_BLANK_EN.
module seg_bcd_scan #(
  parameter int unsigned SCAN_CNT = 50000,
  parameter int unsigned BIN_W    = 20
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [BIN_W-1:0] data,
  input  logic [5:0]       point,
  input  logic             en,
  output logic [5:0]       seg_sel,
  output logic [7:0]       seg_led
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [BIN_W-1:0] MAX_VAL  = BIN_W'(999999);
  localparam logic [15:0]      CNT_LAST = 16'(SCAN_CNT - 1);

  state_t           state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [23:0]      acc_q, acc_d, acc_adj;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [23:0]      bcd_reg_q, bcd_reg_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [5:0]       seg_sel_q, seg_sel_d;
  logic [7:0]       seg_led_q, seg_led_d;
  logic             tick;
  logic [3:0]       nib;
  logic             blank_lz;

  // Per-nibble +3 correction; nibbles never carry into each other.
  function automatic logic [23:0] add3(input logic [23:0] a);
    logic [23:0] r;
    logic [3:0]  n;
    r = a;
    for (int i = 0; i < 6; i++) begin
      n = a[4*i +: 4];
      if (n >= 4'd5) n = n + 4'd3;
      r[4*i +: 4] = n;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'h40;
      4'd1:    c = 7'h79;
      4'd2:    c = 7'h24;
      4'd3:    c = 7'h30;
      4'd4:    c = 7'h19;
      4'd5:    c = 7'h12;
      4'd6:    c = 7'h02;
      4'd7:    c = 7'h78;
      4'd8:    c = 7'h00;
      4'd9:    c = 7'h10;
      default: c = 7'h7F;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    acc_d     = acc_q;
    bit_cnt_d = bit_cnt_q;
    bcd_reg_d = bcd_reg_q;
    acc_adj   = add3(acc_q);
    case (state_q)
      IDLE: begin
        bin_d     = (data > MAX_VAL) ? MAX_VAL : data;
        acc_d     = 24'd0;
        bit_cnt_d = 5'(BIN_W);
        state_d   = CONV;
      end
      CONV: begin
        acc_d     = (acc_adj << 1) | 24'(bin_q[BIN_W-1]);
        bin_d     = bin_q << 1;
        bit_cnt_d = bit_cnt_q - 5'd1;
        if (bit_cnt_q == 5'd1) state_d = DONE;
      end
      DONE: begin
        bcd_reg_d = acc_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
  end

  // Output stage: one-cycle registered view of the current digit slot.
  always_comb begin
    nib = 4'(bcd_reg_q >> {idx_q, 2'b00});
`ifdef SEG_LEADING_ZERO_BLANK_EN
    blank_lz = (idx_q != 3'd0) && ((bcd_reg_q >> {idx_q, 2'b00}) == 24'd0);
`else
    blank_lz = 1'b0;
`endif
    seg_sel_d = 6'h3F;
    seg_led_d = 8'hFF;
    if (en) begin
      seg_sel_d = ~(6'b1 << idx_q);
      seg_led_d = {~point[idx_q], blank_lz ? 7'h7F : seg7(nib)};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 5'd0;
      bcd_reg_q <= 24'd0;
      cnt_q     <= 16'd0;
      idx_q     <= 3'd0;
      seg_sel_q <= 6'h3F;
      seg_led_q <= 8'hFF;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bcd_reg_q <= bcd_reg_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      seg_sel_q <= seg_sel_d;
      seg_led_q <= seg_led_d;
    end
  end

  // Shift datapath is always reloaded in IDLE, so it carries no reset.
  always_ff @(posedge sys_clk) begin
    bin_q <= bin_d;
    acc_q <= acc_d;
  end

  assign seg_sel = seg_sel_q;
  assign seg_led = seg_led_q;

endmodule

// File: tb/tb_seg_bcd_scan.sv
// Directed bench for seg_bcd_scan with SCAN_CNT=4; expected BCD results are queued
// when data is driven and popped when a conversion completes.
module tb_seg_bcd_scan;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [19:0] data;
  logic [5:0]  point;
  logic        en;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_led;

  int total = 0;
  int bad   = 0;
  logic [23:0] exp_q[$];

  seg_bcd_scan #(.SCAN_CNT(4), .BIN_W(20)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .data     (data),
    .point    (point),
    .en       (en),
    .seg_sel  (seg_sel),
    .seg_led  (seg_led)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] t [10];
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return (d < 4'd10) ? t[d] : 8'hFF;
  endfunction

  function automatic logic [7:0] exp_led(input logic [23:0] bcd, input logic [5:0] pt, input int k);
    logic [7:0] c;
    c = seg_code(bcd[4*k +: 4]);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (k > 0 && (bcd >> (4*k)) == 24'd0) c = 8'hFF;
`endif
    c[7] = ~pt[k];
    return c;
  endfunction

  // Wait for n completed conversions (DONE seen), then compare bcd_reg after its update.
  task automatic wait_done(input int n, input string tag);
    int seen = 0;
    logic [23:0] e;
    for (int c = 0; c < 120 && seen < n; c++) begin
      @(negedge sys_clk);
      if (32'(dut.state_q) == 32'd2) seen++;
    end
    if (seen < n) begin
      check({tag, "_timeout"}, 32'(seen), 32'(n));
      return;
    end
    @(posedge sys_clk);
    #1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
    check(tag, 32'(dut.bcd_reg_q), 32'(e));
  endtask

  task automatic convert(input logic [19:0] v, input logic [23:0] e, input string tag);
    @(negedge sys_clk);
    data = v;
    exp_q.push_back(e);
    wait_done(2, tag);
  endtask

  task automatic wait_idle();
    int c = 0;
    @(negedge sys_clk);
    while (32'(dut.state_q) != 32'd0 && c < 40) begin
      @(negedge sys_clk);
      c++;
    end
    if (c >= 40) check("idle_timeout", 32'(c), 32'd0);
  endtask

  task automatic check_frame(input logic [23:0] bcd, input logic [5:0] pt, input string tag);
    int cnt [6];
    int k;
    for (int i = 0; i < 6; i++) cnt[i] = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge sys_clk);
      k = -1;
      for (int i = 0; i < 6; i++) if (seg_sel == ~(6'b1 << i)) k = i;
      if (k < 0) begin
        check({tag, "_sel"}, 32'(seg_sel), 32'h3E);
      end else begin
        cnt[k]++;
        check($sformatf("%s_led%0d", tag, k), 32'(seg_led), 32'(exp_led(bcd, pt, k)));
      end
    end
    for (int i = 0; i < 6; i++) check($sformatf("%s_cnt%0d", tag, i), 32'(cnt[i]), 32'd4);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    data      = 20'd123;
    point     = 6'd0;
    en        = 1'b1;

    // Reset held for 3 cycles
    @(negedge sys_clk);
    check("rst_sel", 32'(seg_sel), 32'h3F);
    check("rst_led", 32'(seg_led), 32'hFF);
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("rst_bcd", 32'(dut.bcd_reg_q), 32'h0);
    sys_rst_n = 1'b1;
    exp_q.push_back(24'h000123);
    wait_done(1, "bcd_123");

    // Main conversion and one full frame
    convert(20'd654321, 24'h654321, "bcd_654321");
    check_frame(24'h654321, 6'd0, "frame654321");

    // Clamp, then zero
    convert(20'hFFFFF, 24'h999999, "bcd_clamp");
    convert(20'd0, 24'h000000, "bcd_zero");
    check_frame(24'h000000, 6'd0, "frame_zero");

    // Enable and decimal point
    point = 6'b000001;
    convert(20'd8, 24'h000008, "bcd_8");
    @(negedge sys_clk);
    en = 1'b0;
    @(negedge sys_clk);
    check("dis_sel", 32'(seg_sel), 32'h3F);
    check("dis_led", 32'(seg_led), 32'hFF);
    en = 1'b1;
    begin
      int c = 0;
      @(negedge sys_clk);
      while (seg_sel != 6'h3E && c < 30) begin
        @(negedge sys_clk);
        c++;
      end
      check("en_units_sel", 32'(seg_sel), 32'h3E);
      check("en_units_led", 32'(seg_led), 32'h00);
    end

    // Reset on CONV cycle 10
    wait_idle();
    repeat (10) @(negedge sys_clk);
    check("pre_rst_state", 32'(dut.state_q), 32'd1);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check("mid_rst_bcd", 32'(dut.bcd_reg_q), 32'h0);
    check("mid_rst_state", 32'(dut.state_q), 32'd0);
    check("mid_rst_idx", 32'(dut.idx_q), 32'd0);
    check("mid_rst_sel", 32'(seg_sel), 32'h3F);
    data = 20'd777777;
    sys_rst_n = 1'b1;
    exp_q.push_back(24'h777777);
    repeat (21) @(posedge sys_clk);
    #1;
    check("post_rst_c21", 32'(dut.bcd_reg_q), 32'h0);
    @(posedge sys_clk);
    #1;
    check("post_rst_c22", 32'(dut.bcd_reg_q), 32'(exp_q.pop_front()));

    // Data change during CONV
    wait_idle();
    data = 20'd111111;
    exp_q.push_back(24'h111111);
    exp_q.push_back(24'h222222);
    repeat (5) @(negedge sys_clk);
    data = 20'd222222;
    wait_done(1, "bcd_first");
    wait_done(1, "bcd_second");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
